ball_game_ctrl: RTL and testbench

Per-frame game controller that drives the positions and radii of the ally and enemy balls into the renderer (memory), replacing its constant inputs. Moves the ally ball from debounced key levels (keys block output) and bounces the enemy ball off the screen edges. Detects collisions and tracks lives and a survival score. Raises perdeu to the renderer on game over. State advances only on a one-cycle frame_tick from the VGA timing block.

---
 rtl/ball_game_ctrl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_ball_game_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ball_game_ctrl.sv
// ball_game_ctrl: per-frame controller for the ally/enemy ball game.
// Moves the ally from key levels, bounces the enemy off the screen edges,
// detects collisions and tracks lives, score and game over.
// Optional build macro: INIMIGO_ACELERA_EN (enemy speeds up over time).
//
// state  | meaning
// ESPERA | idle at start values, waits for any key on a tick
// JOGO   | playing; a collision costs one life
// HIT    | invulnerable for HIT_FRAMES ticks after a hit
// PERDEU | game over; needs a released tick then a pressed tick to restart
module ball_game_ctrl #(
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int PASSO        = 4,
    parameter int VEL_INIMIGA  = 3,
    parameter int RAIO_ALIADA  = 5,
    parameter int RAIO_INIMIGA = 5,
    parameter int VIDAS        = 3,
    parameter int HIT_FRAMES   = 30
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic [3:0]  keysout,
    output logic [9:0]  x_bola_aliada,
    output logic [9:0]  y_bola_aliada,
    output logic [9:0]  raio_bola_aliada,
    output logic [9:0]  x_bola_inimiga,
    output logic [9:0]  y_bola_inimiga,
    output logic [9:0]  raio_bola_inimiga,
    output logic        perdeu,
    output logic [2:0]  vidas,
    output logic [15:0] pontos,
    output logic [1:0]  estado
);

    typedef enum logic [1:0] {
        ESPERA = 2'b00,
        JOGO   = 2'b01,
        HIT    = 2'b10,
        PERDEU = 2'b11
    } state_t;

    localparam int HW = $clog2(HIT_FRAMES + 1);

    localparam logic signed [10:0] AX_MIN  = 11'(RAIO_ALIADA);
    localparam logic signed [10:0] AX_MAX  = 11'(SCREEN_W - 1 - RAIO_ALIADA);
    localparam logic signed [10:0] AY_MIN  = 11'(RAIO_ALIADA);
    localparam logic signed [10:0] AY_MAX  = 11'(SCREEN_H - 1 - RAIO_ALIADA);
    localparam logic signed [10:0] EX_MIN  = 11'(RAIO_INIMIGA);
    localparam logic signed [10:0] EX_MAX  = 11'(SCREEN_W - 1 - RAIO_INIMIGA);
    localparam logic signed [10:0] EY_MIN  = 11'(RAIO_INIMIGA);
    localparam logic signed [10:0] EY_MAX  = 11'(SCREEN_H - 1 - RAIO_INIMIGA);
    localparam logic signed [10:0] PASSO_S = 11'(PASSO);

    localparam logic [9:0] AX0 = 10'd300;
    localparam logic [9:0] AY0 = 10'd300;
    localparam logic [9:0] EX0 = 10'd500;
    localparam logic [9:0] EY0 = 10'd100;

    localparam logic [21:0] R2 =
        22'((RAIO_ALIADA + RAIO_INIMIGA) * (RAIO_ALIADA + RAIO_INIMIGA));

    state_t          state_q, state_d;
    logic [9:0]      ax_q, ay_q, ex_q, ey_q;
    logic [9:0]      ax_d, ay_d, ex_d, ey_d;
    logic            exneg_q, eyneg_q, exneg_d, eyneg_d;
    logic [2:0]      vidas_q, vidas_d;
    logic [15:0]     pontos_q, pontos_d;
    logic [HW-1:0]   hit_q, hit_d;
    logic            col_pend_q, col_pend_d;
    logic            rel_q, rel_d;
    logic            reinit;
    logic [2:0]      vel;

    logic signed [10:0] ax_n, ay_n, ex_n, ey_n, vel_s;
    logic               exneg_n, eyneg_n;

    logic signed [10:0] dx, dy;
    logic [10:0]        adx, ady;
    logic [21:0]        dist2;
    logic               collide;

`ifdef INIMIGO_ACELERA_EN
    logic [2:0] vel_q;
    logic [8:0] frm_q;
    logic       play_tick;

    assign play_tick = frame_tick && (state_q == JOGO || state_q == HIT);
    assign vel       = vel_q;

    // Enemy speed ramps up by one every 512 play ticks, capped at 7.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            vel_q <= 3'(VEL_INIMIGA);
            frm_q <= '0;
        end else if (reinit) begin
            vel_q <= 3'(VEL_INIMIGA);
            frm_q <= '0;
        end else if (play_tick) begin
            frm_q <= frm_q + 9'd1;
            if (frm_q == 9'h1FF && vel_q != 3'd7) begin
                vel_q <= vel_q + 3'd1;
            end
        end
    end
`else
    assign vel = 3'(VEL_INIMIGA);
`endif

    assign vel_s = {8'd0, vel};

    // Collision test on the registered (already updated) positions.
    assign dx      = $signed({1'b0, ax_q}) - $signed({1'b0, ex_q});
    assign dy      = $signed({1'b0, ay_q}) - $signed({1'b0, ey_q});
    assign adx     = $unsigned(dx[10] ? -dx : dx);
    assign ady     = $unsigned(dy[10] ? -dy : dy);
    assign dist2   = 22'(adx) * 22'(adx) + 22'(ady) * 22'(ady);
    assign collide = (dist2 <= R2);

    // Candidate next positions for a play tick, clamped to the screen.
    always_comb begin
        ax_n = {1'b0, ax_q};
        if (keysout[0] && !keysout[1]) begin
            ax_n = ax_n + PASSO_S;
        end else if (keysout[1] && !keysout[0]) begin
            ax_n = ax_n - PASSO_S;
        end
        if (ax_n < AX_MIN) ax_n = AX_MIN;
        else if (ax_n > AX_MAX) ax_n = AX_MAX;

        ay_n = {1'b0, ay_q};
        if (keysout[2] && !keysout[3]) begin
            ay_n = ay_n + PASSO_S;
        end else if (keysout[3] && !keysout[2]) begin
            ay_n = ay_n - PASSO_S;
        end
        if (ay_n < AY_MIN) ay_n = AY_MIN;
        else if (ay_n > AY_MAX) ay_n = AY_MAX;

        exneg_n = exneg_q;
        ex_n    = exneg_q ? ($signed({1'b0, ex_q}) - vel_s) : ($signed({1'b0, ex_q}) + vel_s);
        if (ex_n < EX_MIN) begin
            ex_n    = EX_MIN;
            exneg_n = 1'b0;
        end else if (ex_n > EX_MAX) begin
            ex_n    = EX_MAX;
            exneg_n = 1'b1;
        end

        eyneg_n = eyneg_q;
        ey_n    = eyneg_q ? ($signed({1'b0, ey_q}) - vel_s) : ($signed({1'b0, ey_q}) + vel_s);
        if (ey_n < EY_MIN) begin
            ey_n    = EY_MIN;
            eyneg_n = 1'b0;
        end else if (ey_n > EY_MAX) begin
            ey_n    = EY_MAX;
            eyneg_n = 1'b1;
        end
    end

    // Next-state logic: tick processing, then the collision evaluation cycle.
    always_comb begin
        state_d    = state_q;
        ax_d       = ax_q;
        ay_d       = ay_q;
        ex_d       = ex_q;
        ey_d       = ey_q;
        exneg_d    = exneg_q;
        eyneg_d    = eyneg_q;
        vidas_d    = vidas_q;
        pontos_d   = pontos_q;
        hit_d      = hit_q;
        col_pend_d = col_pend_q;
        rel_d      = rel_q;
        reinit     = 1'b0;

        unique case (state_q)
            ESPERA: begin
                if (frame_tick && keysout != 4'b0000) state_d = JOGO;
            end
            JOGO, HIT: begin
                if (frame_tick) begin
                    ax_d    = ax_n[9:0];
                    ay_d    = ay_n[9:0];
                    ex_d    = ex_n[9:0];
                    ey_d    = ey_n[9:0];
                    exneg_d = exneg_n;
                    eyneg_d = eyneg_n;
                    if (pontos_q != 16'hFFFF) pontos_d = pontos_q + 16'd1;
                    // Frames processed while invulnerable never get evaluated.
                    col_pend_d = (state_q == JOGO);
                    if (state_q == HIT) begin
                        if (hit_q <= HW'(1)) begin
                            hit_d   = '0;
                            state_d = JOGO;
                        end else begin
                            hit_d = hit_q - HW'(1);
                        end
                    end
                end else if (col_pend_q) begin
                    col_pend_d = 1'b0;
                    if (collide) begin
                        vidas_d = vidas_q - 3'd1;
                        if (vidas_q == 3'd1) begin
                            state_d = PERDEU;
                            rel_d   = 1'b0;
                        end else begin
                            state_d = HIT;
                            hit_d   = HW'(HIT_FRAMES);
                        end
                    end
                end
            end
            PERDEU: begin
                if (frame_tick) begin
                    if (keysout == 4'b0000) rel_d = 1'b1;
                    else if (rel_q) reinit = 1'b1;
                end
            end
        endcase

        if (reinit) begin
            state_d    = ESPERA;
            ax_d       = AX0;
            ay_d       = AY0;
            ex_d       = EX0;
            ey_d       = EY0;
            exneg_d    = 1'b1;
            eyneg_d    = 1'b0;
            vidas_d    = 3'(VIDAS);
            pontos_d   = '0;
            hit_d      = '0;
            col_pend_d = 1'b0;
            rel_d      = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q    <= ESPERA;
            ax_q       <= AX0;
            ay_q       <= AY0;
            ex_q       <= EX0;
            ey_q       <= EY0;
            exneg_q    <= 1'b1;
            eyneg_q    <= 1'b0;
            vidas_q    <= 3'(VIDAS);
            pontos_q   <= '0;
            hit_q      <= '0;
            col_pend_q <= 1'b0;
            rel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ax_q       <= ax_d;
            ay_q       <= ay_d;
            ex_q       <= ex_d;
            ey_q       <= ey_d;
            exneg_q    <= exneg_d;
            eyneg_q    <= eyneg_d;
            vidas_q    <= vidas_d;
            pontos_q   <= pontos_d;
            hit_q      <= hit_d;
            col_pend_q <= col_pend_d;
            rel_q      <= rel_d;
        end
    end

    assign x_bola_aliada     = ax_q;
    assign y_bola_aliada     = ay_q;
    assign x_bola_inimiga    = ex_q;
    assign y_bola_inimiga    = ey_q;
    assign raio_bola_aliada  = 10'(RAIO_ALIADA);
    assign raio_bola_inimiga = 10'(RAIO_INIMIGA);
    assign vidas             = vidas_q;
    assign pontos            = pontos_q;
    assign estado            = state_q;
    assign perdeu            = (state_q == PERDEU);

endmodule

// File: tb/tb_ball_game_ctrl.sv
// Directed bench for ball_game_ctrl with a reference model and scoreboard.
module tb_ball_game_ctrl;

    localparam int W     = 640;
    localparam int H     = 480;
    localparam int STEP  = 4;
    localparam int VEL   = 3;
    localparam int RA    = 5;
    localparam int RI    = 5;
    localparam int LIVES = 3;
    localparam int HITF  = 30;

    logic        CLOCK_50;
    logic        reset;
    logic        frame_tick;
    logic [3:0]  keysout;
    logic [9:0]  x_bola_aliada, y_bola_aliada, raio_bola_aliada;
    logic [9:0]  x_bola_inimiga, y_bola_inimiga, raio_bola_inimiga;
    logic        perdeu;
    logic [2:0]  vidas;
    logic [15:0] pontos;
    logic [1:0]  estado;

    ball_game_ctrl dut (
        .CLOCK_50          (CLOCK_50),
        .reset             (reset),
        .frame_tick        (frame_tick),
        .keysout           (keysout),
        .x_bola_aliada     (x_bola_aliada),
        .y_bola_aliada     (y_bola_aliada),
        .raio_bola_aliada  (raio_bola_aliada),
        .x_bola_inimiga    (x_bola_inimiga),
        .y_bola_inimiga    (y_bola_inimiga),
        .raio_bola_inimiga (raio_bola_inimiga),
        .perdeu            (perdeu),
        .vidas             (vidas),
        .pontos            (pontos),
        .estado            (estado)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    initial begin
        #1900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int ax, ay, ex, ey, vid, pts, st, lost;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model state
    int m_ax, m_ay, m_ex, m_ey, m_dx, m_dy;
    int m_vid, m_pts, m_st, m_hit, m_rel;

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    endtask

    task automatic model_init();
        m_ax = 300; m_ay = 300; m_ex = 500; m_ey = 100;
        m_dx = -1;  m_dy = 1;
        m_vid = LIVES; m_pts = 0; m_st = 0; m_hit = 0; m_rel = 0;
    endtask

    task automatic model_tick(input logic [3:0] k);
        int nx, ny, ddx, ddy;
        bit was_jogo;
        if (m_st == 0) begin
            if (k != 4'b0000) m_st = 1;
        end else if (m_st == 3) begin
            if (k == 4'b0000) m_rel = 1;
            else if (m_rel == 1) model_init();
        end else begin
            was_jogo = (m_st == 1);
            nx = m_ax;
            if (k[0] && !k[1]) nx = nx + STEP;
            if (k[1] && !k[0]) nx = nx - STEP;
            ny = m_ay;
            if (k[2] && !k[3]) ny = ny + STEP;
            if (k[3] && !k[2]) ny = ny - STEP;
            m_ax = clampi(nx, RA, W - 1 - RA);
            m_ay = clampi(ny, RA, H - 1 - RA);

            nx = m_ex + m_dx * VEL;
            if (nx < RI) begin nx = RI; m_dx = 1; end
            else if (nx > W - 1 - RI) begin nx = W - 1 - RI; m_dx = -1; end
            m_ex = nx;
            ny = m_ey + m_dy * VEL;
            if (ny < RI) begin ny = RI; m_dy = 1; end
            else if (ny > H - 1 - RI) begin ny = H - 1 - RI; m_dy = -1; end
            m_ey = ny;

            if (m_pts < 65535) m_pts++;
            if (m_st == 2) begin
                m_hit--;
                if (m_hit == 0) m_st = 1;
            end
            ddx = m_ax - m_ex;
            ddy = m_ay - m_ey;
            if (was_jogo && (ddx * ddx + ddy * ddy <= (RA + RI) * (RA + RI))) begin
                m_vid--;
                if (m_vid == 0) begin m_st = 3; m_rel = 0; end
                else begin m_st = 2; m_hit = HITF; end
            end
        end
    endtask

    task automatic push_expect();
        exp_t e;
        e.ax = m_ax; e.ay = m_ay; e.ex = m_ex; e.ey = m_ey;
        e.vid = m_vid; e.pts = m_pts; e.st = m_st; e.lost = (m_st == 3) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_ax"},     int'(x_bola_aliada),  e.ax);
        chk({tag, "_ay"},     int'(y_bola_aliada),  e.ay);
        chk({tag, "_ex"},     int'(x_bola_inimiga), e.ex);
        chk({tag, "_ey"},     int'(y_bola_inimiga), e.ey);
        chk({tag, "_vidas"},  int'(vidas),          e.vid);
        chk({tag, "_pontos"}, int'(pontos),         e.pts);
        chk({tag, "_estado"}, int'(estado),         e.st);
        chk({tag, "_perdeu"}, int'(perdeu),         e.lost);
    endtask

    task automatic do_tick(input logic [3:0] k, input string tag);
        keysout = k;
        @(negedge CLOCK_50);
        frame_tick = 1'b1;
        @(negedge CLOCK_50);
        frame_tick = 1'b0;
        model_tick(k);
        push_expect();
        repeat (3) @(negedge CLOCK_50);
        check_out(tag);
    endtask

    logic [3:0] ck;

    // Directed sequence: reset, start, movement/clamp, mid-game reset,
    // enemy bounces and first hit, chase to game over, restart handshake.
    initial begin
        reset      = 1'b0;
        frame_tick = 1'b0;
        keysout    = 4'b0000;
        repeat (3) @(negedge CLOCK_50);
        model_init();
        push_expect();
        check_out("reset");
        chk("raio_aliada",  int'(raio_bola_aliada),  RA);
        chk("raio_inimiga", int'(raio_bola_inimiga), RI);
        @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        // no tick: nothing moves even with a key held
        keysout = 4'b0001;
        repeat (4) @(negedge CLOCK_50);
        push_expect();
        check_out("espera_no_tick");

        do_tick(4'b0001, "start");
        chk("start_state", int'(estado), 1);
        do_tick(4'b0001, "first_move");
        chk("first_move_ax", int'(x_bola_aliada), 304);
        chk("first_move_ex", int'(x_bola_inimiga), 497);
        chk("first_move_ey", int'(y_bola_inimiga), 103);

        do_tick(4'b0011, "left_right_cancel");
        for (int i = 0; i < 80; i++) do_tick(4'b0010, "left");
        chk("ally_x_min_clamp", int'(x_bola_aliada), RA);

        // asynchronous reset mid-game, checked before any clock edge
        @(negedge CLOCK_50);
        #3;
        reset = 1'b0;
        #2;
        model_init();
        push_expect();
        check_out("mid_reset");
        @(negedge CLOCK_50);
        reset = 1'b1;
        repeat (2) @(negedge CLOCK_50);

        do_tick(4'b1000, "restart");
        for (int i = 0; i < 400; i++) do_tick(4'b0000, "drift");

        for (int i = 0; i < 3000 && m_st != 3; i++) begin
            ck = 4'b0000;
            if (m_ex > m_ax) ck[0] = 1'b1;
            if (m_ex < m_ax) ck[1] = 1'b1;
            if (m_ey > m_ay) ck[2] = 1'b1;
            if (m_ey < m_ay) ck[3] = 1'b1;
            do_tick(ck, "chase");
        end
        chk("reach_perdeu_estado", int'(estado), 3);
        chk("reach_perdeu_flag",   int'(perdeu), 1);
        chk("reach_perdeu_vidas",  int'(vidas),  0);

        do_tick(4'b0001, "perdeu_held");
        do_tick(4'b0100, "perdeu_held2");
        do_tick(4'b0000, "perdeu_release");
        do_tick(4'b0001, "perdeu_press");
        chk("reinit_estado", int'(estado), 0);
        chk("reinit_ax",     int'(x_bola_aliada), 300);
        chk("reinit_ex",     int'(x_bola_inimiga), 500);
        chk("reinit_vidas",  int'(vidas), LIVES);
        chk("reinit_pontos", int'(pontos), 0);
        do_tick(4'b0001, "after_reinit_start");
        do_tick(4'b0001, "after_reinit_move");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
